// File: rtl/npu_cmd_pkg.sv
// Shared types and constants for the NPU command path.
//   job_cmd_t    : one layer job as queued from the softcore (in_ptr, out_ptr, size)
//   disp_state_e : dispatcher FSM encoding
//   clamp_size   : limit an element count to the largest size the unit accepts
package npu_cmd_pkg;

  localparam int unsigned MaxSizeDefault = 256;
  localparam int unsigned CmdWidth       = 96;

  typedef struct packed {
    logic [31:0] in_ptr;
    logic [31:0] out_ptr;
    logic [31:0] size;
  } job_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRespond
  } disp_state_e;

  function automatic logic [31:0] clamp_size(input logic [31:0] size,
                                             input logic [31:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued job commands.
//   push_i/wdata_i : write, ignored when full
//   pop_i/rdata_o  : rdata_o shows the head; pop ignored when empty
//   full_o/empty_o : occupancy flags
// Push and pop may coincide at any fill level.
module cmd_fifo #(
  parameter int unsigned Width = 96,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/softmax_job_dispatcher.sv
// Queues softmax layer jobs and issues them one at a time to the softmax unit.
//   cmd_*    : job command input (valid/ready), buffered in cmd_fifo
//   unit_*   : start/ready/done job interface to softmax_unit
//   rsp_*    : in-order response (valid/ready) with result, timeout and clamp flags
//   busy_o   : a job is in flight or queued
//   jobs_done_o : count of popped responses, wraps
module softmax_job_dispatcher
  import npu_cmd_pkg::*;
#(
  parameter int unsigned Depth         = 4,
  parameter int unsigned MaxSize       = MaxSizeDefault,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_in_ptr_i,
  input  logic [31:0] cmd_out_ptr_i,
  input  logic [31:0] cmd_size_i,
  output logic        unit_start_o,
  output logic [31:0] unit_input_ptr_o,
  output logic [31:0] unit_output_ptr_o,
  output logic [31:0] unit_size_o,
  input  logic        unit_ready_i,
  input  logic        unit_done_i,
  input  logic [31:0] unit_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_timeout_o,
  output logic        rsp_clamped_o,
  output logic        busy_o,
  output logic [15:0] jobs_done_o
);

  localparam int unsigned    WdW       = $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WdOne     = 1;
  localparam logic [WdW-1:0] WdLast    = WdW'(TimeoutCycles - 1);
  localparam logic [31:0]    MaxSize32 = 32'(MaxSize);

  disp_state_e    state_q, state_d;
  job_cmd_t       fifo_wdata, fifo_rdata, job_q;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [31:0]    head_size;
  logic           start_q, clamped_q, timeout_q;
  logic [31:0]    result_q;
  logic [WdW-1:0] wdog_q;
  logic [15:0]    jobs_done_q;
  logic           issue_fire, done_take, wd_expire, rsp_fire;

  assign fifo_wdata = '{in_ptr: cmd_in_ptr_i, out_ptr: cmd_out_ptr_i, size: cmd_size_i};

  cmd_fifo #(
    .Width(CmdWidth),
    .Depth(Depth)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (cmd_valid_i),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign head_size  = clamp_size(fifo_rdata.size, MaxSize32);
  assign fifo_pop   = (state_q == StIdle) && !fifo_empty;
  assign issue_fire = (state_q == StIssue) && unit_ready_i;
  // start_q is high only in the first WAIT_DONE cycle; a done there is stale.
  assign done_take  = (state_q == StWaitDone) && unit_done_i && !start_q;
  assign wd_expire  = (state_q == StWaitDone) && (wdog_q == WdLast);
  assign rsp_fire   = (state_q == StRespond) && rsp_ready_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!fifo_empty) state_d = (head_size == '0) ? StRespond : StIssue;
      StIssue:    if (unit_ready_i) state_d = StWaitDone;
      StWaitDone: if (done_take || wd_expire) state_d = StRespond;
      StRespond:  if (rsp_ready_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready_o = !fifo_full;
    rsp_valid_o = (state_q == StRespond);
    busy_o      = (state_q != StIdle) || !fifo_empty;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_q       <= '0;
      start_q     <= 1'b0;
      clamped_q   <= 1'b0;
      timeout_q   <= 1'b0;
      result_q    <= '0;
      wdog_q      <= '0;
      jobs_done_q <= '0;
    end else begin
      start_q <= issue_fire;
      if (fifo_pop) begin
        job_q     <= '{in_ptr: fifo_rdata.in_ptr, out_ptr: fifo_rdata.out_ptr, size: head_size};
        clamped_q <= (fifo_rdata.size > MaxSize32);
        result_q  <= '0;
        timeout_q <= 1'b0;
      end
      if (issue_fire)                   wdog_q <= '0;
      else if (state_q == StWaitDone)   wdog_q <= wdog_q + WdOne;
      // Done beats an expiry in the same cycle.
      if (done_take)      result_q  <= unit_result_i;
      else if (wd_expire) timeout_q <= 1'b1;
      if (rsp_fire) jobs_done_q <= jobs_done_q + 16'd1;
    end
  end

  assign unit_start_o      = start_q;
  assign unit_input_ptr_o  = job_q.in_ptr;
  assign unit_output_ptr_o = job_q.out_ptr;
  assign unit_size_o       = job_q.size;
  assign rsp_result_o      = result_q;
  assign rsp_timeout_o     = timeout_q;
  assign rsp_clamped_o     = clamped_q;
  assign jobs_done_o       = jobs_done_q;

endmodule

// File: tb/tb_softmax_job_dispatcher.sv
// Self-checking bench for softmax_job_dispatcher with a small behavioural softmax unit.
module tb_softmax_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_in_ptr, cmd_out_ptr, cmd_size;
  logic        unit_start, unit_ready, unit_done;
  logic [31:0] unit_input_ptr, unit_output_ptr, unit_size, unit_result;
  logic        rsp_valid, rsp_ready, rsp_timeout, rsp_clamped, busy;
  logic [31:0] rsp_result;
  logic [15:0] jobs_done;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_jobs  = 0;
  int unsigned start_cnt = 0;

  always #5 clk = ~clk;

  softmax_job_dispatcher #(
    .Depth(4),
    .MaxSize(256),
    .TimeoutCycles(64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_in_ptr_i     (cmd_in_ptr),
    .cmd_out_ptr_i    (cmd_out_ptr),
    .cmd_size_i       (cmd_size),
    .unit_start_o     (unit_start),
    .unit_input_ptr_o (unit_input_ptr),
    .unit_output_ptr_o(unit_output_ptr),
    .unit_size_o      (unit_size),
    .unit_ready_i     (unit_ready),
    .unit_done_i      (unit_done),
    .unit_result_i    (unit_result),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_result_o     (rsp_result),
    .rsp_timeout_o    (rsp_timeout),
    .rsp_clamped_o    (rsp_clamped),
    .busy_o           (busy),
    .jobs_done_o      (jobs_done)
  );

  // Behavioural unit: done model_delay cycles after accepting a start; never if delay is 0.
  logic        model_stall = 1'b0;
  int unsigned model_delay = 20;
  logic        model_use_ptr = 1'b0;
  logic [31:0] model_res = '0;
  logic        m_busy;
  int unsigned m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      unit_done   <= 1'b0;
      unit_result <= '0;
    end else begin
      unit_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 >= model_delay) begin
          m_busy      <= 1'b0;
          unit_done   <= 1'b1;
          unit_result <= model_use_ptr ? (unit_input_ptr ^ 32'h5A5A_0000) : model_res;
        end
      end else if (unit_start && model_delay != 0) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end
  end
  assign unit_ready = !m_busy && !model_stall;

  always @(posedge clk) if (unit_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_in_ptr = a; cmd_out_ptr = b; cmd_size = s;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int n);
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    if (!rsp_valid) chk({name, "_rsp_wait"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!unit_start && n < 400) begin @(negedge clk); n++; end
    chk({name, "_start_seen"}, 32'(unit_start), 32'd1);
  endtask

  task automatic pop_rsp(input string name, input logic [31:0] res, input logic to,
                         input logic cl);
    int n;
    wait_rsp(name, n);
    chk({name, "_result"}, rsp_result, res);
    chk({name, "_timeout"}, 32'(rsp_timeout), 32'(to));
    chk({name, "_clamped"}, 32'(rsp_clamped), 32'(cl));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_jobs++;
    chk({name, "_jobs_done"}, 32'(jobs_done), exp_jobs);
    chk({name, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] in_ptr;
    logic [31:0] out_ptr;
    logic [31:0] size;
    logic [31:0] unit_res;
    logic [31:0] exp_size;
    logic [31:0] exp_res;
    logic        exp_cl;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int unsigned s0;
    logic [31:0] held;

    vecs[0] = '{32'h1000, 32'h2000, 32'd10,         32'h1,         32'd10,  32'h1,         1'b0};
    vecs[1] = '{32'h3000, 32'h4000, 32'd256,        32'hCAFE_F00D, 32'd256, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{32'h5000, 32'h6000, 32'd257,        32'h1234_5678, 32'd256, 32'h1234_5678, 1'b1};
    vecs[3] = '{32'h7000, 32'h8000, 32'd300,        32'h2,         32'd256, 32'h2,         1'b1};
    vecs[4] = '{32'h9000, 32'hA000, 32'd0,          32'hBAD0_BAD0, 32'd0,   32'h0,         1'b0};
    vecs[5] = '{32'hB000, 32'hC000, 32'hFFFF_FFFF,  32'hDEAD_BEEF, 32'd256, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{32'hD000, 32'hE000, 32'd1,          32'hFFFF_FFFF, 32'd1,   32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_in_ptr = '0; cmd_out_ptr = '0; cmd_size = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_unit_start", 32'(unit_start), 32'd0);
    chk("rst_jobs_done", 32'(jobs_done), 32'd0);

    // Table: single jobs, including size boundaries
    for (int i = 0; i < NV; i++) begin
      model_res = vecs[i].unit_res;
      s0 = start_cnt;
      push(vecs[i].in_ptr, vecs[i].out_ptr, vecs[i].size);
      if (vecs[i].exp_size == 0) begin
        n = 0;
        while (!rsp_valid && n < 5) begin @(negedge clk); n++; end
        chk($sformatf("v%0d_zero_latency_ok", i), 32'(n <= 1), 32'd1);
        pop_rsp($sformatf("v%0d", i), vecs[i].exp_res, 1'b0, vecs[i].exp_cl);
        chk($sformatf("v%0d_no_start", i), start_cnt, s0);
      end else begin
        wait_start($sformatf("v%0d", i));
        chk($sformatf("v%0d_in_ptr", i), unit_input_ptr, vecs[i].in_ptr);
        chk($sformatf("v%0d_out_ptr", i), unit_output_ptr, vecs[i].out_ptr);
        chk($sformatf("v%0d_size", i), unit_size, vecs[i].exp_size);
        @(negedge clk);
        chk($sformatf("v%0d_start_pulse", i), 32'(unit_start), 32'd0);
        pop_rsp($sformatf("v%0d", i), vecs[i].exp_res, 1'b0, vecs[i].exp_cl);
        chk($sformatf("v%0d_one_start", i), start_cnt, s0 + 1);
      end
    end

    // Queue fill while the unit stalls; responses must come back in push order
    model_stall = 1'b1; model_use_ptr = 1'b1;
    s0 = start_cnt;
    for (int j = 0; j < 5; j++) push(32'h100 * (j + 1), 32'h9000 + j, 32'd8);
    chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    chk("fill_no_start", start_cnt, s0);
    model_stall = 1'b0;
    for (int j = 0; j < 5; j++)
      pop_rsp($sformatf("ord%0d", j), (32'h100 * (j + 1)) ^ 32'h5A5A_0000, 1'b0, 1'b0);
    chk("ord_starts", start_cnt, s0 + 5);

    // Watchdog: unit never completes
    model_use_ptr = 1'b0; model_delay = 0;
    push(32'h4400, 32'h4800, 32'd16);
    wait_start("to");
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("to_latency", n, 32'd64);
    push(32'h5500, 32'h5800, 32'd4);
    model_delay = 20; model_res = 32'h0000_00AB;
    s0 = start_cnt;
    pop_rsp("to", 32'h0, 1'b1, 1'b0);
    wait_start("after_to");
    chk("after_to_in_ptr", unit_input_ptr, 32'h5500);
    pop_rsp("after_to", 32'hAB, 1'b0, 1'b0);

    // Back-pressure: response held while rsp_ready stays low
    model_res = 32'h0000_0077;
    push(32'h6600, 32'h6800, 32'd12);
    push(32'h7700, 32'h7800, 32'd12);
    wait_rsp("bp", n);
    s0 = start_cnt;
    held = unit_input_ptr;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_result%0d", k), rsp_result, 32'h77);
    end
    chk("bp_no_start", start_cnt, s0);
    chk("bp_ptr_held", held, 32'h6600);
    chk("bp_ptr_now", unit_input_ptr, 32'h6600);
    model_res = 32'h0000_0088;
    pop_rsp("bp1", 32'h77, 1'b0, 1'b0);
    pop_rsp("bp2", 32'h88, 1'b0, 1'b0);

    // Asynchronous reset in WAIT_DONE with a second job queued
    model_delay = 0;
    push(32'h8800, 32'h8900, 32'd5);
    push(32'h9900, 32'h9A00, 32'd5);
    wait_start("ar");
    repeat (5) @(negedge clk);
    chk("ar_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ar_in_ptr", unit_input_ptr, 32'd0);
    chk("ar_size", unit_size, 32'd0);
    chk("ar_jobs_done", 32'(jobs_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_jobs = 0;
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("ar_busy_after", 32'(busy), 32'd0);
    chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
    chk("ar_no_start", start_cnt, s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
